icache_dm: RTL



---
 rtl/icache_dm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits are answered combinationally from register storage; misses refill one
// full line over an AXI INCR burst. fencei drops every line and poisons any
// refill already in flight so self-modified code is fetched again.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | serving hits; a miss latches idx/tag and starts a refill
// ST_AR   | arvalid high with the line address, waiting for arready
// ST_R    | rready high, writing one word per rvalid beat until rlast
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fencei,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] inst,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BEAT_W = OFF_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag_arr [SETS];
  logic [31:0]       r_data    [SETS][LINE_WORDS];

  logic [IDX_W-1:0]  r_miss_idx;
  logic [TAG_W-1:0]  r_miss_tag;
  logic [BEAT_W-1:0] r_beat;
  logic              r_discard;

  logic [BEAT_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_miss;
  logic              w_beat;
  logic              w_last;

  assign w_off = addr[OFF_W-1:2];
  assign w_idx = addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag = addr[31:OFF_W+IDX_W];

  // Lookup is gated by IDLE so nothing reads as a hit while a line is in flight.
  assign hit  = (r_state == ST_IDLE) & r_valid[w_idx] & (r_tag_arr[w_idx] == w_tag);
  assign inst = r_data[w_idx][w_off];

  assign w_miss = (r_state == ST_IDLE) & ~hit;
  assign w_beat = (r_state == ST_R) & rvalid;
  assign w_last = w_beat & rlast;

  // The miss registers only change in IDLE, so araddr is stable through AR.
  assign araddr  = {r_miss_tag, r_miss_idx, {OFF_W{1'b0}}};
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Next-state and AXI handshake outputs.
  always_comb begin
    w_state_next = r_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) w_state_next = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_next = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Miss bookkeeping, valid bits and the discard flag that poisons fenced refills.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= '0;
      r_discard  <= 1'b0;
      r_beat     <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
    end else begin
      if (w_miss) begin
        r_miss_idx <= w_idx;
        r_miss_tag <= w_tag;
        r_beat     <= '0;
        r_discard  <= 1'b0;
      end else if (fencei && (r_state != ST_IDLE)) begin
        r_discard  <= 1'b1;
      end
      if (w_beat) r_beat <= r_beat + BEAT_W'(1);
      // A fence on the rlast beat wins, so that line also ends up invalid.
      if (fencei)      r_valid             <= '0;
      else if (w_last) r_valid[r_miss_idx] <= ~r_discard;
    end
  end

  // Line storage; not reset because the valid bits qualify every read.
  always_ff @(posedge clock) begin
    if (w_beat) begin
      r_data[r_miss_idx][r_beat] <= rdata;
      if (rlast) r_tag_arr[r_miss_idx] <= r_miss_tag;
    end
  end

  // The burst length is fixed, so rlast must arrive exactly on the final word.
  a_rlast_align: assert property (@(posedge clock) disable iff (reset)
    w_beat |-> (rlast == (r_beat == LAST_BEAT)));

  // Error responses are not acted upon; the data is kept but flagged here.
  a_rresp_okay: assert property (@(posedge clock) disable iff (reset)
    w_beat |-> (rresp == 2'b00))
    else $warning("icache_dm: nonzero rresp %0d on refill beat", rresp);

  // The fetch unit only issues word-aligned addresses.
  a_addr_aligned: assert property (@(posedge clock) disable iff (reset)
    addr[1:0] == 2'b00);

endmodule
